uart_tx_arb: RTL

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: shares one UART transmitter between 4 byte-stream requesters.
// A grant is held for a whole packet, which ends on the byte flagged by req_last.
// Optional feature macro: UART_TX_ARB_RR_EN selects round-robin arbitration.
// Without it, arbitration is fixed priority and the lowest index wins.
module uart_tx_arb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_last,
  output logic [3:0]  req_ready,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic [3:0]  grant,
  output logic        active
);

  localparam int unsigned NREQ   = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [NREQ-1:0]     ready_q, ready_d;
  logic                tx_en_q, tx_en_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic                active_q, active_d;
  logic                last_q, last_d;

  logic [NREQ-1:0]     win_c;
  logic [IDX_W-1:0]    gidx_c;

`ifdef UART_TX_ARB_RR_EN
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    win_idx_c;
  logic [IDX_W-1:0]    cand_c;

  // Round-robin winner: first valid requester after the last granted index
  always_comb begin
    win_c     = '0;
    win_idx_c = '0;
    cand_c    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand_c = ptr_q + IDX_W'(k);
      if (win_c == '0 && req_valid[cand_c]) begin
        win_c[cand_c] = 1'b1;
        win_idx_c     = cand_c;
      end
    end
  end
`else
  // Fixed-priority winner: lowest valid index
  always_comb begin
    win_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_c == '0 && req_valid[IDX_W'(i)]) begin
        win_c[IDX_W'(i)] = 1'b1;
      end
    end
  end
`endif

  // Index of the current packet owner, used to select its byte lane
  always_comb begin
    gidx_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_q[IDX_W'(i)]) begin
        gidx_c = IDX_W'(i);
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ready_d   = '0;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    last_d    = last_q;
`ifdef UART_TX_ARB_RR_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if ((|req_valid) && !tx_busy) begin
          grant_d = win_c;
`ifdef UART_TX_ARB_RR_EN
          ptr_d   = win_idx_c;
`endif
          state_d = SEND;
        end
      end
      SEND: begin
        // Owner may pause mid-packet; grant is held until its byte shows up
        if (req_valid[gidx_c]) begin
          tx_en_d   = 1'b1;
          ready_d   = grant_q;
          tx_data_d = req_data[{gidx_c, 3'b000} +: BYTE_W];
          last_d    = req_last[gidx_c];
          state_d   = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            grant_d = '0;
            state_d = IDLE;
          end else begin
            state_d = SEND;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
    active_d = |grant_d;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ready_q   <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      active_q  <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ready_q   <= ready_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      active_q  <= active_d;
      last_q    <= last_d;
    end
  end

`ifdef UART_TX_ARB_RR_EN
  // Last-granted pointer; resets to 3 so requester 0 is searched first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= IDX_W'(3);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign req_ready = ready_q;
  assign tx_en     = tx_en_q;
  assign tx_data   = tx_data_q;
  assign grant     = grant_q;
  assign active    = active_q;

endmodule
